// File: rtl/sub8_seq_if.sv
// sub8_seq_if: operand/result valid-ready bundle for the sequential subtractor
interface sub8_seq_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic ovf;
  logic zero;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf, zero);
  modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf, zero);
endinterface

// File: rtl/sub8_seq.sv
// sub8_seq: two-slice sequential subtractor, low half first, borrow carried through a register
module sub8_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  sub8_seq_if.slave s
);
  localparam int H = WIDTH / 2;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb, diff;
  logic rbin, brw, bout, ovf, zero;
  logic [H:0] lo, hi;
  assign lo = {1'b0, ra[H-1:0]} - {1'b0, rb[H-1:0]} - {{H{1'b0}}, rbin};
  assign hi = {1'b0, ra[WIDTH-1:H]} - {1'b0, rb[WIDTH-1:H]} - {{H{1'b0}}, brw};
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (s.in_valid ? LO : IDLE) :
          state == LO   ? HI :
          state == HI   ? DONE :
                          (s.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      rbin <= 1'b0;
      brw <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.in_valid) begin
          ra <= s.a;
          rb <= s.b;
          rbin <= s.bin;
        end
        LO: {brw, diff[H-1:0]} <= lo;
        HI: begin
          diff[WIDTH-1:H] <= hi[H-1:0];
          bout <= hi[H];
          ovf <= (ra[WIDTH-1] != rb[WIDTH-1]) && (hi[H-1] != ra[WIDTH-1]);
          zero <= {hi[H-1:0], diff[H-1:0]} == '0;
        end
        default: ;
      endcase
    end
  end
  assign s.in_ready = state == IDLE;
  assign s.out_valid = state == DONE;
  assign s.diff = diff;
  assign s.bout = bout;
  assign s.ovf = ovf;
  assign s.zero = zero;
endmodule

// File: tb/tb_sub8_seq.sv
// tb_sub8_seq: scoreboard bench with directed cases and randomized traffic under random backpressure
module tb_sub8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd_bp = 1'b0;
  logic prev_ov = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [10:0] expq[$];
  int accq[$];

  sub8_seq_if #(.WIDTH(8)) bus();
  sub8_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int d, sd;
    logic [7:0] r;
    d = int'(x) - int'(y) - int'(bi);
    sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
    r = d[7:0];
    return {r, d < 0, (sd < -128) || (sd > 127), r == 8'h00};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      accq.delete();
      prev_ov = 1'b0;
    end else begin
      chk("hs_exclusive", int'(bus.in_ready && bus.out_valid), 0);
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.a, bus.b, bus.bin));
        accq.push_back(cyc + 1);
      end
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got diff=%0h with empty scoreboard", bus.diff);
        end else begin
          if (!prev_ov) chk("latency", cyc, accq[0] + 2);
          chk("result", int'({bus.diff, bus.bout, bus.ovf, bus.zero}), int'(expq[0]));
          if (bus.out_ready) begin
            void'(expq.pop_front());
            void'(accq.pop_front());
          end
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  always @(posedge clk) if (rnd_bp) begin
    #1;
    bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int n = 0;
    bus.a = x;
    bus.b = y;
    bus.bin = bi;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.bin = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || !bus.in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending=%0d required 0", expq.size());
    end
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_outputs"}, int'({bus.diff, bus.bout, bus.ovf, bus.zero}), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b0;
    send(8'h5A, 8'h3C, 1'b0);
    wait_idle();
    send(8'h10, 8'h01, 1'b0);
    send(8'h00, 8'h01, 1'b0);
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'hFF, 1'b0);
    send(8'h05, 8'h04, 1'b1);
    send(8'h00, 8'hFF, 1'b1);
    send(8'hA7, 8'hA7, 1'b0);
    send(8'h33, 8'hFF, 1'b1);
    wait_idle();
    bus.out_ready = 1'b0;
    send(8'h5A, 8'h3C, 1'b0);
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.in_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("bp_out_valid", int'(bus.out_valid), 1);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_diff", int'(bus.diff), 'h1E);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    send(8'hFF, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cleared("abort");
    send(8'h03, 8'h02, 1'b0);
    wait_idle();
    chk("post_abort_diff", int'({bus.diff, bus.bout}), 'h01 << 1);
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
